// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared bus widths, memory-select encodings and state types
//               for the unified RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = 4;
  localparam int RAM_WE_W = 4;

  localparam logic [SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [SEL_W-1:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundles the fetch port, the data port and the RAM port of the
//               arbiter. The master modport is the environment side
//               (requesters plus the RAM itself); the slave modport is the
//               arbiter.
//   inst_*  : fetch request / grant / read data
//   data_*  : load-store request / grant / reject / completion
//   ram_*   : strobe, byte enables, word address, write data, read data
//   busy    : an access is outstanding
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic                inst_req;
  logic [ADDR_W-1:0]   inst_addr;
  logic                inst_ack;
  logic                inst_rvalid;
  logic [DATA_W-1:0]   inst_rdata;

  logic                data_req;
  logic                data_we;
  logic [SEL_W-1:0]    data_sel;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_ack;
  logic                data_misalign;
  logic                data_rvalid;
  logic [DATA_W-1:0]   data_rdata;

  logic                ram_en;
  logic [RAM_WE_W-1:0] ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  logic                busy;

  modport master (
    output inst_req, inst_addr,
    output data_req, data_we, data_sel, data_addr, data_wdata,
    output ram_rdata,
    input  inst_ack, inst_rvalid, inst_rdata,
    input  data_ack, data_misalign, data_rvalid, data_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_we, data_sel, data_addr, data_wdata,
    input  ram_rdata,
    output inst_ack, inst_rvalid, inst_rdata,
    output data_ack, data_misalign, data_rvalid, data_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter_store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Combinational data-request lane logic. Flags misaligned or
//               illegal size encodings, shifts the size mask into byte write
//               enables, and replicates store data across the lanes.
//   i_sel       : size select (byte / half / word)
//   i_addr_lo   : byte offset within the word
//   i_we        : request is a store
//   i_wdata     : right-justified store data
//   o_misalign  : request must be rejected
//   o_ram_we    : byte enables (zero for loads and rejects)
//   o_ram_wdata : lane-replicated store data
// Revision    : 1.0 - initial release
// ============================================================================
module store_align
  import ram_arbiter_pkg::*;
(
  input  wire logic [SEL_W-1:0]    i_sel,
  input  wire logic [1:0]          i_addr_lo,
  input  wire logic                i_we,
  input  wire logic [DATA_W-1:0]   i_wdata,
  output logic                     o_misalign,
  output logic [RAM_WE_W-1:0]      o_ram_we,
  output logic [DATA_W-1:0]        o_ram_wdata
);

  always_comb begin
    o_misalign  = 1'b1;
    o_ram_wdata = '0;
    case (i_sel)
      MEM_SEL_BYTE: begin
        o_misalign  = 1'b0;
        o_ram_wdata = {4{i_wdata[7:0]}};
      end
      MEM_SEL_HALF: begin
        o_misalign  = i_addr_lo[0];
        o_ram_wdata = {2{i_wdata[15:0]}};
      end
      MEM_SEL_WORD: begin
        o_misalign  = (i_addr_lo != 2'b00);
        o_ram_wdata = i_wdata;
      end
      default: begin
        o_misalign  = 1'b1;
        o_ram_wdata = '0;
      end
    endcase
  end

  // The shift cannot overflow the 4 lanes once alignment has been accepted.
  assign o_ram_we = (i_we && !o_misalign) ? (i_sel << i_addr_lo) : '0;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one synchronous RAM port between instruction fetch and
//               the MEM-stage data requester. Data has priority unless fetch
//               has lost STARVE_LIMIT contests in a row. One access is
//               tracked through a fixed RAM latency; a new grant may issue in
//               the completion cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : fetch, data and RAM ports (slave view)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  ram_arbiter_if.slave bus
);

  localparam logic [2:0] C_LAT        = 3'(RAM_LATENCY);
  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] C_WORD_MASK = ~ADDR_W'(3);

  arb_state_t r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_starve;
  owner_t     r_owner;
  logic       r_store;

  logic                w_done;
  logic                w_window;
  logic                w_inst_win;
  logic                w_data_win;
  logic                w_data_go;
  logic                w_grant;
  logic                w_misalign;
  logic [RAM_WE_W-1:0] w_align_we;
  logic [DATA_W-1:0]   w_align_wdata;
  logic                w_inst_rvalid;
  logic                w_data_rvalid;

  store_align u_store_align (
    .i_sel       (bus.data_sel),
    .i_addr_lo   (bus.data_addr[1:0]),
    .i_we        (bus.data_we),
    .i_wdata     (bus.data_wdata),
    .o_misalign  (w_misalign),
    .o_ram_we    (w_align_we),
    .o_ram_wdata (w_align_wdata)
  );

  assign w_done   = (r_state == ST_WAIT) && (r_cnt == 3'd1);
  // Gating with rst keeps every combinational output low while in reset.
  assign w_window = rst && ((r_state == ST_IDLE) || w_done);

  // Data wins a contest unless fetch has reached the starvation limit.
  assign w_data_win = w_window && bus.data_req &&
                      !(bus.inst_req && (r_starve == C_STARVE_MAX));
  assign w_inst_win = w_window && bus.inst_req && !w_data_win;
  assign w_data_go  = w_data_win && !w_misalign;
  assign w_grant    = w_inst_win || w_data_go;

  assign bus.inst_ack      = w_inst_win;
  assign bus.data_ack      = w_data_win;
  assign bus.data_misalign = w_data_win && w_misalign;

  assign bus.ram_en    = w_grant;
  assign bus.ram_we    = w_data_go ? w_align_we : '0;
  assign bus.ram_addr  = w_inst_win ? (bus.inst_addr & C_WORD_MASK) :
                         w_data_go  ? (bus.data_addr & C_WORD_MASK) : '0;
  assign bus.ram_wdata = (w_data_go && bus.data_we) ? w_align_wdata : '0;

  assign w_inst_rvalid   = w_done && (r_owner == OWN_INST);
  assign w_data_rvalid   = w_done && (r_owner == OWN_DATA);
  assign bus.inst_rvalid = w_inst_rvalid;
  assign bus.data_rvalid = w_data_rvalid;
  assign bus.inst_rdata  = w_inst_rvalid ? bus.ram_rdata : '0;
  assign bus.data_rdata  = (w_data_rvalid && !r_store) ? bus.ram_rdata : '0;
  assign bus.busy        = (r_state == ST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_starve <= 4'd0;
      r_owner  <= OWN_INST;
      r_store  <= 1'b0;
    end else begin
      // A rejected data request still counts as a data win here.
      if (w_inst_win) begin
        r_starve <= 4'd0;
      end else if (w_data_win && bus.inst_req && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + 4'd1;
      end

      if (w_grant) begin
        r_state <= ST_WAIT;
        r_cnt   <= C_LAT;
        r_owner <= w_inst_win ? OWN_INST : OWN_DATA;
        r_store <= w_data_go && bus.data_we;
      end else if (r_state == ST_WAIT) begin
        if (r_cnt == 3'd1) begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Scoreboard bench for ram_arbiter. One instance runs with
//               RAM_LATENCY=1 under a queue-based monitor; a second instance
//               with RAM_LATENCY=3 covers the multi-cycle wait and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter_if bus1();
  ram_arbiter_if bus3();

  ram_arbiter #(.RAM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_arbiter #(.RAM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Simple RAM: returns a word derived from the last strobed address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  logic [31:0] r_ram1_addr = '0;
  logic [31:0] r_ram3_addr = '0;
  always @(posedge clk) if (bus1.ram_en) r_ram1_addr <= bus1.ram_addr;
  always @(posedge clk) if (bus3.ram_en) r_ram3_addr <= bus3.ram_addr;
  assign bus1.ram_rdata = mem_word(r_ram1_addr);
  assign bus3.ram_rdata = mem_word(r_ram3_addr);

  typedef struct packed {
    logic        is_data;
    logic        mis;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ack_t;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } rv_t;

  ack_t ackq[$];
  rv_t  rvq[$];
  int   atq[$];

  function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void exp_inst(input logic [31:0] a);
    ack_t e;
    rv_t  r;
    e.is_data = 1'b0; e.mis = 1'b0; e.en = 1'b1; e.we = 4'b0000;
    e.addr = {a[31:2], 2'b00}; e.wdata = '0;
    ackq.push_back(e);
    r.is_data = 1'b0; r.rdata = mem_word({a[31:2], 2'b00});
    rvq.push_back(r);
  endfunction

  function automatic void exp_data(input logic we, input logic [31:0] a, input logic mis,
                                   input logic [3:0] rwe, input logic [31:0] rwd);
    ack_t e;
    rv_t  r;
    e.is_data = 1'b1; e.mis = mis; e.en = !mis; e.we = rwe;
    e.addr = {a[31:2], 2'b00}; e.wdata = rwd;
    ackq.push_back(e);
    if (!mis) begin
      r.is_data = 1'b1;
      r.rdata   = we ? 32'h0 : mem_word({a[31:2], 2'b00});
      rvq.push_back(r);
    end
  endfunction

  // Monitor for the latency-1 instance: every ack and rvalid pops the queue.
  always @(negedge clk) begin
    ack_t e;
    rv_t  r;
    int   t;
    if (bus1.inst_ack || bus1.data_ack) begin
      if (ackq.size() == 0) begin
        chk("unexpected_ack", {bus1.inst_ack, bus1.data_ack}, 2'b00);
      end else begin
        e = ackq.pop_front();
        chk("ack",
            {bus1.data_ack, bus1.inst_ack, bus1.data_misalign, bus1.ram_en, bus1.ram_we,
             e.en ? bus1.ram_addr : 32'h0, (e.we != 4'b0) ? bus1.ram_wdata : 32'h0},
            {e.is_data, !e.is_data, e.mis, e.en, e.we,
             e.en ? e.addr : 32'h0, (e.we != 4'b0) ? e.wdata : 32'h0});
      end
      if (bus1.ram_en) atq.push_back(cyc);
    end
    if (bus1.inst_rvalid || bus1.data_rvalid) begin
      if (rvq.size() == 0) begin
        chk("unexpected_rvalid", {bus1.inst_rvalid, bus1.data_rvalid}, 2'b00);
      end else begin
        r = rvq.pop_front();
        chk("rvalid",
            {bus1.data_rvalid, bus1.inst_rvalid, r.is_data ? bus1.data_rdata : bus1.inst_rdata},
            {r.is_data, !r.is_data, r.rdata});
      end
      if (atq.size() != 0) begin
        t = atq.pop_front();
        chk("rvalid_latency", 80'(cyc - t), 80'd1);
      end
    end
  end

  task automatic drive_inst(input logic [31:0] a);
    bit got;
    got = 1'b0;
    bus1.inst_req  = 1'b1;
    bus1.inst_addr = a;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus1.inst_ack;
    end
    if (!got) chk("inst_ack_timeout", 80'd0, 80'd1);
    @(posedge clk); #1;
    bus1.inst_req = 1'b0;
  endtask

  task automatic drive_data(input logic we, input logic [3:0] sel,
                            input logic [31:0] a, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    bus1.data_req   = 1'b1;
    bus1.data_we    = we;
    bus1.data_sel   = sel;
    bus1.data_addr  = a;
    bus1.data_wdata = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus1.data_ack;
    end
    if (!got) chk("data_ack_timeout", 80'd0, 80'd1);
    @(posedge clk); #1;
    bus1.data_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    bus1.inst_req = 0; bus1.inst_addr = 0; bus1.data_req = 0; bus1.data_we = 0;
    bus1.data_sel = 0; bus1.data_addr = 0; bus1.data_wdata = 0;
    bus3.inst_req = 0; bus3.inst_addr = 0; bus3.data_req = 0; bus3.data_we = 0;
    bus3.data_sel = 0; bus3.data_addr = 0; bus3.data_wdata = 0;

    repeat (2) @(negedge clk);
    chk("reset_outputs_dut1",
        {79'd0, |{bus1.inst_ack, bus1.inst_rvalid, bus1.inst_rdata, bus1.data_ack,
                  bus1.data_misalign, bus1.data_rvalid, bus1.data_rdata, bus1.ram_en,
                  bus1.ram_we, bus1.ram_addr, bus1.ram_wdata, bus1.busy}}, 80'd0);
    chk("reset_outputs_dut3",
        {79'd0, |{bus3.inst_ack, bus3.inst_rvalid, bus3.inst_rdata, bus3.data_ack,
                  bus3.data_misalign, bus3.data_rvalid, bus3.data_rdata, bus3.ram_en,
                  bus3.ram_we, bus3.ram_addr, bus3.ram_wdata, bus3.busy}}, 80'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Back-to-back fetches.
    exp_inst(32'h0); exp_inst(32'h4); exp_inst(32'h8);
    c0 = cyc;
    drive_inst(32'h0); drive_inst(32'h4); drive_inst(32'h8);
    chk("fetch_back_to_back_cycles", 80'(cyc - c0), 80'd3);
    repeat (2) @(posedge clk); #1;

    // Stores, loads and rejects.
    exp_data(1, 32'h13, 0, 4'b1000, 32'hA5A5A5A5);
    drive_data(1, MEM_SEL_BYTE, 32'h13, 32'h000000A5);
    exp_data(1, 32'h22, 0, 4'b1100, 32'hBEEFBEEF);
    drive_data(1, MEM_SEL_HALF, 32'h22, 32'h0000BEEF);
    exp_data(1, 32'h44, 0, 4'b1111, 32'h12345678);
    drive_data(1, MEM_SEL_WORD, 32'h44, 32'h12345678);
    exp_data(0, 32'h40, 0, 4'b0000, 32'h0);
    drive_data(0, MEM_SEL_WORD, 32'h40, 32'h0);
    exp_data(0, 32'h41, 0, 4'b0000, 32'h0);
    drive_data(0, MEM_SEL_BYTE, 32'h41, 32'h0);
    exp_data(0, 32'h21, 1, 4'b0000, 32'h0);
    drive_data(0, MEM_SEL_HALF, 32'h21, 32'h0);
    exp_data(0, 32'h20, 1, 4'b0000, 32'h0);
    drive_data(0, 4'b0111, 32'h20, 32'h0);
    exp_data(1, 32'h42, 1, 4'b0000, 32'h0);
    drive_data(1, MEM_SEL_WORD, 32'h42, 32'hFFFFFFFF);
    repeat (2) @(posedge clk); #1;

    // Continuous contest: D D D D I D D D D I D.
    for (int k = 0; k < 4; k++) exp_data(0, 32'h100 + 32'(4 * k), 0, 4'b0000, 32'h0);
    exp_inst(32'h200);
    for (int k = 4; k < 8; k++) exp_data(0, 32'h100 + 32'(4 * k), 0, 4'b0000, 32'h0);
    exp_inst(32'h204);
    exp_data(0, 32'h120, 0, 4'b0000, 32'h0);
    fork
      begin
        for (int k = 0; k < 9; k++) drive_data(0, MEM_SEL_WORD, 32'h100 + 32'(4 * k), 32'h0);
      end
      begin
        drive_inst(32'h200);
        drive_inst(32'h204);
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("ack_queue_drained", 80'(ackq.size()), 80'd0);
    chk("rvalid_queue_drained", 80'(rvq.size()), 80'd0);

    // Latency 3: data grant at cycle 0, inst grant at completion, then reset.
    bus3.data_req = 1; bus3.data_we = 0; bus3.data_sel = MEM_SEL_WORD; bus3.data_addr = 32'h80;
    bus3.inst_req = 1; bus3.inst_addr = 32'h300;
    @(negedge clk);
    chk("lat3_c0", {bus3.inst_ack, bus3.data_ack, bus3.data_misalign, bus3.ram_en, bus3.busy,
                    bus3.ram_addr}, {5'b01010, 32'h80});
    @(posedge clk); #1;
    bus3.data_req = 0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      chk("lat3_wait", {bus3.busy, bus3.inst_ack, bus3.data_rvalid, bus3.inst_rvalid, bus3.ram_en},
          5'b10000);
    end
    @(negedge clk);
    chk("lat3_c3", {bus3.busy, bus3.inst_ack, bus3.data_rvalid, bus3.inst_rvalid, bus3.ram_en,
                    bus3.ram_addr, bus3.data_rdata}, {5'b11101, 32'h300, mem_word(32'h80)});
    @(posedge clk); #1;
    bus3.inst_req = 0;
    @(negedge clk);
    chk("lat3_c4_busy", {79'd0, bus3.busy}, 80'd1);
    #2 rst = 1'b0;
    #1;
    chk("lat3_reset_outputs",
        {79'd0, |{bus3.inst_ack, bus3.inst_rvalid, bus3.inst_rdata, bus3.data_ack,
                  bus3.data_misalign, bus3.data_rvalid, bus3.data_rdata, bus3.ram_en,
                  bus3.ram_we, bus3.ram_addr, bus3.ram_wdata, bus3.busy}}, 80'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lat3_no_rvalid_after_reset", {78'd0, bus3.inst_rvalid, bus3.busy}, 80'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single synchronous unified RAM port between the instruction-fetch requester and the MEM-stage data requester. It arbitrates with data priority plus an anti-starvation limit, and tracks one outstanding access through a fixed RAM latency. It aligns store byte-enables and write data, and rejects misaligned data requests without touching the RAM. It sits between the IF/MEM stages and the RAM. Load-data extraction stays in WB.

## Interface
Parameters:
- RAM_LATENCY, 1, cycles from RAM enable to valid `ram_rdata` (legal 1–4).
- STARVE_LIMIT, 4, consecutive lost contests after which inst wins (legal 1–15).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request, held until `inst_ack`.
- inst_addr  in  `ADDR_BUS`  word-aligned fetch address.
- inst_ack  out  1  grant pulse; request consumed this cycle.
- inst_rvalid  out  1  fetch data valid pulse.
- inst_rdata  out  `DATA_BUS`  fetch data.
- data_req  in  1  load/store request, held until `data_ack`.
- data_we  in  1  1 = store.
- data_sel  in  `MEM_SEL_BUS`  0001 byte, 0011 half, 1111 word.
- data_addr  in  `ADDR_BUS`  byte address.
- data_wdata  in  `DATA_BUS`  store data, right-justified.
- data_ack  out  1  grant or reject pulse.
- data_misalign  out  1  reject pulse, coincident with `data_ack`.
- data_rvalid  out  1  completion pulse for loads and stores.
- data_rdata  out  `DATA_BUS`  raw RAM word for loads; 0 for stores.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  byte write enables.
- ram_addr  out  `ADDR_BUS`  {addr[31:2],2'b00}.
- ram_wdata  out  `DATA_BUS`  lane-replicated store data.
- ram_rdata  in  `DATA_BUS`  RAM read data.
- busy  out  1  access outstanding.

## Operation
- State IDLE: no access outstanding. State WAIT: one access outstanding; `cnt` holds the remaining cycles and `owner` records inst or data.
- Grant is evaluated in IDLE, or in WAIT when `cnt`==1 (the completion cycle).
- Grant rule when both requesters are pending: data wins unless `starve`==STARVE_LIMIT, in which case inst wins.
- `starve` increments when inst loses a contest, clears on any inst grant, and saturates at STARVE_LIMIT.
- A lone requester always wins.
- Misalignment check, data requests only. Illegal cases:
  - sel 0011 with addr[0]=1;
  - sel 1111 with addr[1:0]≠0;
  - any sel outside {0001, 0011, 1111}.
- A misaligned request that wins arbitration gets `data_ack` and `data_misalign` in the same cycle. It produces no `ram_en`, does not leave IDLE, and produces no `data_rvalid`. It counts as a data win for `starve`.
- On a valid grant:
  - `ram_en`=1 and `ram_addr` is the word address.
  - `ram_we` = data_we ? (sel << addr[1:0]) : 0.
  - `ram_wdata`: byte is replicated ×4; half is replicated ×2; word is passed unchanged.
  - `cnt` loads RAM_LATENCY; go to WAIT and set `owner`.
- In WAIT, `cnt` decrements each cycle. When `cnt`==1:
  - the owner's `*_rvalid` pulses;
  - `*_rdata` = `ram_rdata` (data stores give 0);
  - a new grant may issue in the same cycle; if none, go to IDLE.
- Inst grants never assert `ram_we`.
- `busy` = (state==WAIT).

## Timing
- Reset: all outputs 0, state IDLE, `cnt`=0, `starve`=0.
- Reset asserted mid-WAIT aborts the access; no `rvalid` follows.
- `*_ack`, `data_misalign` and all `ram_*` outputs are combinational from the current request and state.
- `*_rvalid` and `*_rdata` are combinational from `cnt`, `owner` and `ram_rdata`.
- Latency: grant in cycle N → `rvalid` in cycle N+RAM_LATENCY.
- Throughput: one access per RAM_LATENCY cycles; back-to-back with RAM_LATENCY=1.
- A requester that drops its `req` before ack is simply not served. Requesters must not change request fields while waiting for ack.
- At most one `ack` per cycle. At most one `rvalid` per cycle.

## Structure
- Add to `bus.v`: `MEM_SEL_BYTE` 4'b0001, `MEM_SEL_HALF` 4'b0011, `MEM_SEL_WORD` 4'b1111, `RAM_WE_BUS` 3:0.
- Sub-module `store_align` (combinational): computes the misalign flag, `ram_we` and `ram_wdata` from sel, addr[1:0], we and wdata.
- The FSM, `cnt`, `starve` and `owner` stay in `ram_arbiter`.

## Test plan
- RAM_LATENCY=1, inst-only fetches at 0x0, 0x4, 0x8 on consecutive cycles → three acks back-to-back. `inst_rvalid` appears one cycle after each ack with the RAM word.
- Store byte 0xA5 at 0x13 → `ram_we`=1000, `ram_wdata`=0xA5A5A5A5, `ram_addr`=0x10. `data_rvalid` follows with `data_rdata`=0.
- Load half at 0x21 → `data_ack` and `data_misalign` in the same cycle, `ram_en`=0, no `data_rvalid`. Same result for sel=0111.
- STARVE_LIMIT=4, both requesting continuously → grant pattern D D D D I D D D D I …
- RAM_LATENCY=3, grant data at cycle 0 → `busy` in cycles 1–3, `data_rvalid` at cycle 3 with an inst grant in the same cycle. Assert `rst` low at cycle 4 → outputs 0 and no `inst_rvalid`.
